// File: rtl/debug_pkg.sv
// debug_pkg: shared types and constants for the debugger UART paths
package debug_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, GAP} uart_tx_state_t;

    localparam logic [31:0] DBG_ALIVE_CODE = 32'h0000_00AE;
    localparam logic        UART_IDLE_LVL  = 1'b1;

    typedef struct packed {
        logic [2:0]  nbytes;
        logic [31:0] data;
    } resp_entry_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit cycle counter emitting a tick on the last cycle of each bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic clk,
    input  logic n_Rst,
    input  logic load,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count;

    assign bit_tick = en && count == CW'(CLKS_PER_BIT - 1);

    // load parks the counter at zero so every bit starts on a fresh count
    always_ff @(posedge clk or negedge n_Rst)
        if (!n_Rst)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en)
            count <= bit_tick ? '0 : count + CW'(1);

endmodule

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: buffers debugger response words and sends 1-4 bytes each as 8N1 frames
import debug_pkg::*;

module uart_resp_tx #(
    parameter int CLKS_PER_BIT   = 234,
    parameter int STOP_BITS      = 1,
    parameter int INTER_WORD_GAP = 0
) (
    input  logic        clk,
    input  logic        n_Rst,
    input  logic [31:0] word_data,
    input  logic [2:0]  word_nbytes,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic        word_done
);

    localparam int GW = $clog2(INTER_WORD_GAP + 2);

    resp_entry_t    fifo [2];
    resp_entry_t    head;
    logic           wr_ptr, rd_ptr;
    logic [1:0]     occ;
    uart_tx_state_t state;
    logic [31:0]    shreg;
    logic [7:0]     cur;
    logic [2:0]     byte_cnt, bit_cnt;
    logic           stop_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           push, pop, tick, head_ok, run;

    assign word_ready = occ != 2'd2;
    assign push       = word_valid && word_ready;
    assign pop        = state == LOAD;
    assign head       = fifo[rd_ptr];
    assign head_ok    = head.nbytes != 3'd0 && head.nbytes <= 3'd4;
    assign run        = state == START || state == DATA || state == STOP;
    assign cur        = shreg[31:24];
    assign tx         = state == START ? 1'b0 : state == DATA ? cur[bit_cnt] : UART_IDLE_LVL;
    assign busy       = state != IDLE || occ != 2'd0;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .n_Rst    (n_Rst),
        .load     (!run),
        .en       (run),
        .bit_tick (tick)
    );

    // word storage; contents are only meaningful where occupancy says so
    always_ff @(posedge clk)
        if (push)
            fifo[wr_ptr] <= '{nbytes: word_nbytes, data: word_data};

    // occupancy and pointers; a simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk or negedge n_Rst)
        if (!n_Rst) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            occ    <= occ + 2'(push) - 2'(pop);
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
        end

    // frame sequencer; the selected top byte is left-aligned so the current byte is always shreg[31:24]
    always_ff @(posedge clk or negedge n_Rst)
        if (!n_Rst) begin
            state     <= IDLE;
            shreg     <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            gap_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: if (occ != 2'd0) state <= LOAD;
                LOAD: begin
                    shreg    <= head.data << {3'd4 - head.nbytes, 3'b000};
                    byte_cnt <= head.nbytes;
                    state    <= head_ok ? START : IDLE;
                end
                START: if (tick) begin
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (tick) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    stop_cnt <= 1'b0;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP: if (tick) begin
                    if (stop_cnt != 1'(STOP_BITS - 1))
                        stop_cnt <= 1'b1;
                    else if (byte_cnt > 3'd1) begin
                        byte_cnt <= byte_cnt - 3'd1;
                        shreg    <= shreg << 8;
                        state    <= START;
                    end else begin
                        word_done <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= INTER_WORD_GAP == 0 ? IDLE : GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GW'(INTER_WORD_GAP - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx: decodes the tx line independently and checks it against a byte-queue model
module tb_uart_resp_tx;

    localparam int CPB   = 234;
    localparam int FRAME = CPB * 10;

    logic        clk = 1'b0;
    logic        n_Rst = 1'b1;
    logic [31:0] word_data = '0;
    logic [2:0]  word_nbytes = '0;
    logic        word_valid = 1'b0;
    logic        word_ready, tx, busy, word_done;

    int total = 0, bad = 0, cyc = 0;
    int exp_words = 0, done_pulses = 0, tot_pulses = 0, tot_hi = 0;
    logic [7:0] got[$], exp_q[$];
    int fall_t[$], done_t[$];
    logic abort = 1'b0, done_prev = 1'b0, mon_st;
    logic [7:0] mon_b;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  n;
        int          frames;
        int          len;
    } vec_t;
    vec_t vecs[4];

    uart_resp_tx dut (
        .clk         (clk),
        .n_Rst       (n_Rst),
        .word_data   (word_data),
        .word_nbytes (word_nbytes),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .tx          (tx),
        .busy        (busy),
        .word_done   (word_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge n_Rst) abort = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -99999;
    endfunction

    // reference model: a valid word contributes its selected bytes, top first, and one word_done
    function automatic void model_push(input logic [31:0] d, input logic [2:0] n);
        if (n >= 3'd1 && n <= 3'd4) begin
            for (int i = int'(n) - 1; i >= 0; i--) exp_q.push_back(8'(d >> (8 * i)));
            exp_words++;
        end
    endfunction

    task automatic clr();
        got.delete();
        exp_q.delete();
        fall_t.delete();
        done_t.delete();
        done_pulses = 0;
        exp_words = 0;
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] n, output int h);
        int k = 0;
        @(negedge clk);
        while (!word_ready && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if (!word_ready) chk("push_ready_timeout", 0, 1);
        word_data   = d;
        word_nbytes = n;
        word_valid  = 1'b1;
        @(posedge clk);
        #1;
        h           = cyc;
        word_valid  = 1'b0;
        word_data   = $urandom;
        word_nbytes = 3'($urandom);
        model_push(d, n);
    endtask

    task automatic wait_done(input int n, input int limit);
        int k = 0;
        while (done_pulses < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("done_wait", int'(done_pulses >= n), 1);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        @(negedge clk);
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", int'(busy), 0);
    endtask

    task automatic check_line(input string name);
        chk({name, " nbytes_seen"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", name, i), int'(got[i]), int'(exp_q[i]));
        chk({name, " word_done_count"}, done_pulses, exp_words);
    endtask

    // word_done monitor
    always @(negedge clk) begin
        if (word_done === 1'b1) tot_hi++;
        if (word_done === 1'b1 && done_prev !== 1'b1) begin
            done_pulses++;
            tot_pulses++;
            done_t.push_back(cyc);
        end
        done_prev = word_done;
    end

    // line decoder: mid-bit sampling from the falling start edge
    initial forever begin
        @(negedge clk);
        if (n_Rst === 1'b1 && tx === 1'b0) begin
            abort = 1'b0;
            fall_t.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            mon_st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (!abort) begin
                chk("start_bit", int'(mon_st), 0);
                chk("stop_bit", int'(tx), 1);
                got.push_back(mon_b);
            end
        end
    end

    initial begin
        int h, h1, h2, h3, viol, k;
        vecs[0] = '{32'h0000_00AE, 3'd2, 2, 2 * FRAME};
        vecs[1] = '{32'hDEAD_BEEF, 3'd4, 4, 4 * FRAME};
        vecs[2] = '{32'h0000_007E, 3'd1, 1, FRAME};
        vecs[3] = '{32'hFFFF_00A5, 3'd1, 1, FRAME};

        #2 n_Rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", int'(tx), 1);
        chk("rst word_ready", int'(word_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst word_done", int'(word_done), 0);
        n_Rst = 1'b1;

        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || word_ready !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("idle violations", viol, 0);
        chk("idle frames", fall_t.size(), 0);

        foreach (vecs[v]) begin
            clr();
            push(vecs[v].data, vecs[v].n, h);
            wait_done(1, vecs[v].len + 100);
            chk($sformatf("vec%0d latency", v), qat(fall_t, 0) - h, 2);
            chk($sformatf("vec%0d length", v), qat(done_t, 0) - qat(fall_t, 0), vecs[v].len);
            chk($sformatf("vec%0d frames", v), fall_t.size(), vecs[v].frames);
            for (int i = 1; i < fall_t.size(); i++)
                chk($sformatf("vec%0d spacing%0d", v, i), fall_t[i] - fall_t[i - 1], FRAME);
            check_line($sformatf("vec%0d", v));
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d busy_after", v), int'(busy), 0);
        end

        clr();
        push(32'h1122_3344, 3'd4, h1);
        push(32'h0000_0055, 3'd1, h2);
        @(negedge clk);
        chk("three ready_full", int'(word_ready), 0);
        chk("three busy_full", int'(busy), 1);
        push(32'h0000_A5A5, 3'd2, h3);
        chk("three second_accept", h2 - h1, 1);
        chk("three third_accept", h3 - h1, 3);
        wait_done(3, 8 * FRAME);
        chk("three frames", fall_t.size(), 7);
        chk("three w2_start", qat(fall_t, 4) - qat(done_t, 0), 2);
        chk("three w3_start", qat(fall_t, 5) - qat(done_t, 1), 2);
        check_line("three");
        wait_idle(FRAME);

        clr();
        push(32'h1234_5678, 3'd0, h1);
        push(32'h0000_007E, 3'd1, h2);
        wait_done(1, 2 * FRAME);
        wait_idle(FRAME);
        chk("zero frames", fall_t.size(), 1);
        check_line("zero");

        clr();
        push(32'hDEAD_BEEF, 3'd4, h);
        k = 0;
        while (fall_t.size() < 2 && k < 3 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("abort second_start", fall_t.size(), 2);
        repeat (500) @(negedge clk);
        #3 n_Rst = 1'b0;
        #1;
        chk("abort tx", int'(tx), 1);
        chk("abort busy", int'(busy), 0);
        chk("abort word_ready", int'(word_ready), 1);
        chk("abort word_done", int'(word_done), 0);
        repeat (3) @(negedge clk);
        n_Rst = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        exp_words = 0;
        repeat (FRAME) @(negedge clk);
        check_line("abort");

        clr();
        push(32'h0000_003C, 3'd1, h);
        wait_done(1, FRAME + 100);
        chk("post_reset latency", qat(fall_t, 0) - h, 2);
        check_line("post_reset");

        clr();
        for (int w = 0; w < 3; w++) begin
            repeat ($urandom_range(0, 400)) @(negedge clk);
            push($urandom, 3'($urandom_range(0, 5)), h);
        end
        wait_done(exp_words, 13 * FRAME);
        wait_idle(13 * FRAME);
        check_line("random");

        chk("word_done width", tot_hi, tot_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
